// File: rtl/dff_const_pkg.sv
// dff_const_pkg: shared constants and types for the constant-load register.
//   DFF_CONST_DEF_WIDTH   : default register width
//   DFF_CONST_SYNC_STAGES : depth of the optional reset synchroniser
//   dff_const_lat_t       : reset-release latency in clock edges (1 or 3)
`timescale 1ns/1ps
package dff_const_pkg;

  localparam int unsigned DFF_CONST_DEF_WIDTH   = 1;
  localparam int unsigned DFF_CONST_SYNC_STAGES = 2;

  typedef int unsigned dff_const_lat_t;

  // Release latency: the load edge, plus one edge per synchroniser stage
  // when the synchroniser is present.
  localparam dff_const_lat_t DFF_CONST_LAT_DIRECT = 1;
  localparam dff_const_lat_t DFF_CONST_LAT_SYNC   =
    dff_const_lat_t'(DFF_CONST_SYNC_STAGES) + 1;

  function automatic dff_const_lat_t dff_const_release_lat(input bit sync_en);
    return sync_en ? DFF_CONST_LAT_SYNC : DFF_CONST_LAT_DIRECT;
  endfunction

endpackage

// File: rtl/dff_const_1_rst_sync.sv
// rst_sync: reset synchroniser, asynchronous assert / synchronous deassert.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset in
//   reset_sync : active-high reset out; asserts immediately with reset,
//                deasserts STAGES rising edges after reset is sampled low
`timescale 1ns/1ps
module rst_sync
  import dff_const_pkg::*;
#(
  parameter int unsigned STAGES = DFF_CONST_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  output logic reset_sync
);

  logic [STAGES-1:0] chain;

  // Chain presets to all ones; zeros shift in from bit 0 once reset drops.
  // A left shift keeps this legal for any depth, including one stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= chain << 1;
    end
  end

  assign reset_sync = chain[STAGES-1];

endmodule

// File: rtl/dff_const_1.sv
// dff_const_1: constant-load register used as a post-reset ready indicator.
// While reset is high q holds RST_VAL and settled is 0. On every rising
// clock edge with reset low q loads CONST_VAL and settled goes to 1, so the
// outputs change exactly once per reset release.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset
//   q       : registered output, WIDTH bits
//   settled : registered flag, 1 once q has taken CONST_VAL
// Build option: define DFF_CONST_RST_SYNC_EN to route reset through a
// 2-flop synchroniser (immediate assert, release delayed by 2 edges).
`timescale 1ns/1ps
module dff_const_1
  import dff_const_pkg::*;
#(
  parameter int unsigned          WIDTH     = DFF_CONST_DEF_WIDTH,
  parameter logic [WIDTH-1:0]     RST_VAL   = '0,
  parameter logic [WIDTH-1:0]     CONST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic             settled
);

  logic reset_reg;

`ifdef DFF_CONST_RST_SYNC_EN
  rst_sync #(
    .STAGES (DFF_CONST_SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .reset      (reset),
    .reset_sync (reset_reg)
  );
`else
  assign reset_reg = reset;
`endif

  // Both outputs come straight from these flops; reset only reaches them
  // through the asynchronous clear/preset.
  always_ff @(posedge clk or posedge reset_reg) begin
    if (reset_reg) begin
      q       <= RST_VAL;
      settled <= 1'b0;
    end else begin
      q       <= CONST_VAL;
      settled <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dff_const_1.sv
// tb_dff_const_1: directed self-checking bench for dff_const_1.
// Three instances share clk/reset: default 1-bit, 8-bit A5/3C, and a 4-bit
// instance whose reset and load values are equal. All outputs are packed
// into one observation vector compared against hand-written constants.
`timescale 1ns/1ps
module tb_dff_const_1;

`ifdef DFF_CONST_RST_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // {q, settled, q_w, settled_w, q_eq, settled_eq}
  localparam logic [15:0] EXP_RST = {1'b0, 1'b0, 8'hA5, 1'b0, 4'h9, 1'b0};
  localparam logic [15:0] EXP_LD  = {1'b1, 1'b1, 8'h3C, 1'b1, 4'h9, 1'b1};

  logic       clk = 1'b0;
  bit         clk_en = 1'b1;
  logic       reset;
  logic       q;
  logic       settled;
  logic [7:0] q_w;
  logic       settled_w;
  logic [3:0] q_eq;
  logic       settled_eq;
  logic [15:0] obs;
  logic [15:0] exp_v;

  int tests = 0;
  int fails = 0;

  always #10 if (clk_en) clk = ~clk;

  assign obs = {q, settled, q_w, settled_w, q_eq, settled_eq};

  dff_const_1 dut (
    .clk     (clk),
    .reset   (reset),
    .q       (q),
    .settled (settled)
  );

  dff_const_1 #(
    .WIDTH     (8),
    .RST_VAL   (8'hA5),
    .CONST_VAL (8'h3C)
  ) dut_w (
    .clk     (clk),
    .reset   (reset),
    .q       (q_w),
    .settled (settled_w)
  );

  dff_const_1 #(
    .WIDTH     (4),
    .RST_VAL   (4'h9),
    .CONST_VAL (4'h9)
  ) dut_eq (
    .clk     (clk),
    .reset   (reset),
    .q       (q_eq),
    .settled (settled_eq)
  );

  task automatic wait_to(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic test_reset;
    time pts[4] = '{5, 500, 1000, 1540};
    for (int i = 0; i < 4; i++) begin
      wait_to(pts[i]);
      tests++;
      if (obs !== EXP_RST) begin
        fails++;
        $display("FAIL reset_hold t=%0t: got %h expected %h", $time, obs, EXP_RST);
      end
    end
  endtask

  task automatic test_release;
    wait_to(1547);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_to(1551 + 20 * k);
      exp_v = (k + 1 >= LAT) ? EXP_LD : EXP_RST;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL release_edge%0d: got %h expected %h", k + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset;
    wait_to(2000);
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== EXP_RST) begin
      fails++;
      $display("FAIL mid_assert_immediate: got %h expected %h", obs, EXP_RST);
    end
    wait_to(2060);
    tests++;
    if (obs !== EXP_RST) begin
      fails++;
      $display("FAIL mid_assert_held: got %h expected %h", obs, EXP_RST);
    end
    wait_to(2100);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_to(2111 + 20 * k);
      exp_v = (k + 1 >= LAT) ? EXP_LD : EXP_RST;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL rerelease_edge%0d: got %h expected %h", k + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== EXP_LD) begin
        fails++;
        $display("FAIL hold_cycle%0d t=%0t: got %h expected %h", i, $time, obs, EXP_LD);
      end
    end
  endtask

  task automatic test_coincident;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    // release lands in the same time step as the edge, after the flops fired
    #0 reset = 1'b0;
    #1;
    tests++;
    if (obs !== EXP_RST) begin
      fails++;
      $display("FAIL coincident_edge0: got %h expected %h", obs, EXP_RST);
    end
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      exp_v = (k >= LAT) ? EXP_LD : EXP_RST;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL coincident_edge%0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_stopped_clock;
    @(negedge clk);
    #1 clk_en = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== EXP_RST) begin
      fails++;
      $display("FAIL stopped_assert: got %h expected %h", obs, EXP_RST);
    end
    #20 reset = 1'b0;
    #200;
    tests++;
    if (obs !== EXP_RST) begin
      fails++;
      $display("FAIL stopped_no_edge: got %h expected %h", obs, EXP_RST);
    end
    clk_en = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      exp_v = (k >= LAT) ? EXP_LD : EXP_RST;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL stopped_edge%0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_release();
    test_mid_reset();
    test_hold();
    test_coincident();
    test_stopped_clock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_const_1.md
# dff_const_1

Constant-load register: a flop bank that is forced to its reset value while `reset` is high and loads a fixed constant on the first rising clock edge after reset releases. It then holds that constant indefinitely. It serves as a post-reset "alive/ready" indicator and as a synthesis check block, since the flop is expected to optimise to a constant-driven cell in the netlist. It sits at the leaf level with no data inputs.

## Interface
- `WIDTH`, default 1: number of register bits.
- `RST_VAL`, default `'0`: value of `q` while in reset (WIDTH bits).
- `CONST_VAL`, default `'1`: value loaded after reset (WIDTH bits, all ones by default).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `q` output, `WIDTH` bits: registered output.
- `settled` output, 1 bit: registered; 1 once `q` has taken `CONST_VAL`.

## Operation
- While `reset`=1: `q`=`RST_VAL` and `settled`=0, regardless of `clk`.
- Every rising `clk` edge with `reset`=0: `q` <= `CONST_VAL`, `settled` <= 1.
- There are no other state changes. `q` never returns to `RST_VAL` except through reset.
- If `RST_VAL` == `CONST_VAL`, `q` is constant. `settled` still follows the rule above.
- `q` and `settled` come directly from flops, with no combinational path from `reset` to the outputs other than the asynchronous clear/preset.

## Timing
- Reset assertion takes effect immediately, with no clock needed. `q` goes to `RST_VAL` within the same delta or time step.
- Reset can assert mid-operation, at any time. The outputs go to reset values at once. Re-release repeats the load sequence.
- Deassertion latency with the macro off: `q`=`CONST_VAL` on the first rising edge at which `reset` is sampled 0. That is 1 edge.
- Deassertion latency with the macro on: 3 edges (2 synchroniser stages, then the load).
- Reset falling coincident with a `clk` edge: that edge counts as reset-held. The load occurs on the next edge.

## Configuration
- `DFF_CONST_RST_SYNC_EN` defined:
  - `reset` passes through a 2-flop reset synchroniser: asynchronous assert, synchronous deassert.
  - The synchronised reset drives the register.
  - Assertion is still immediate. Release is delayed by 2 clock edges.
- Not defined: `reset` drives the register directly, giving 1-edge release latency.

## Structure
- Package `dff_const_pkg` holds:
  - `DFF_CONST_DEF_WIDTH` = 1
  - `DFF_CONST_SYNC_STAGES` = 2
  - typedef `dff_const_lat_t`, an integer giving expected release latency in edges (1 or 3).
- Sub-module `rst_sync`, instantiated only under the macro:
  - ports `clk`, `reset` in, `reset_sync` out.
  - a stage count parameter, default from the package.

## Test plan
- Baseline timing: 20 ns clock (edges at 10, 30, …), `reset`=1 from 0 to 1547 ns.
  - `q`=0 and `settled`=0 throughout reset.
  - `q`=1 and `settled`=1 from 1550 ns (first edge after release), macro off.
  - `q` stays 1 through 3000 ns.
- Mid-operation reset: re-assert `reset` at 2000 ns for 100 ns between edges.
  - `q`=0 at 2000 ns without a clock edge.
  - `q`=1 at the first edge after 2100 ns.
- Coincident release: `reset` falls exactly at edge 1550 ns.
  - `q` remains 0 at 1550 ns and becomes 1 at 1570 ns.
- Wide configuration: `WIDTH`=8, `RST_VAL`=8'hA5, `CONST_VAL`=8'h3C.
  - `q`=8'hA5 in reset.
  - `q`=8'h3C one edge after release, then held for 100 cycles.
- Macro on, baseline stimulus:
  - `q`=0 at 1550 ns and 1570 ns.
  - `q`=1 at 1590 ns.
  - Re-assertion still clears `q` immediately.
- Stopped clock: `clk` held low after release.
  - `q` stays `RST_VAL` until the first rising edge, then loads `CONST_VAL`.
